// File: rtl/power_sense_pkg.sv
// Shared definitions for the power-sense input conditioner: register map and
// per-channel debounce states.
package power_sense_pkg;

  localparam logic [1:0] REG_STATE  = 2'd0;
  localparam logic [1:0] REG_EDGE   = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_VERIFY = 1'b1
  } ch_state_e;

endpackage

// File: rtl/power_sense_debounce_ch.sv
// One sense channel: synchronizer chain followed by a STABLE/VERIFY debounce
// FSM that toggles its level only after the new value has held long enough.
module power_sense_debounce_ch
  import power_sense_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 raw_i,
  input  logic [CNT_WIDTH-1:0] thresh_i,
  output logic                 level_o,
  output logic                 changed_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  ch_state_e              state_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic                   level_q;

  logic                   synced;
  logic [CNT_WIDTH-1:0]   effThresh;
  logic [CNT_WIDTH:0]     countNext;
  logic                   toggleNow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign synced    = sync_q[SYNC_STAGES-1];
  assign effThresh = (thresh_i == '0) ? CNT_WIDTH'(1) : thresh_i;
  // Extra bit keeps the compare correct even when count+1 wraps the counter width.
  assign countNext = {1'b0, count_q} + (CNT_WIDTH+1)'(1);
  assign toggleNow = (state_q == ST_VERIFY) && (synced != level_q) &&
                     (countNext >= {1'b0, effThresh});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STABLE;
      count_q <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (synced != level_q) begin
            state_q <= ST_VERIFY;
            count_q <= '0;
          end
        end
        ST_VERIFY: begin
          if (synced == level_q) begin
            state_q <= ST_STABLE;
          end else if (toggleNow) begin
            level_q <= ~level_q;
            state_q <= ST_STABLE;
          end else begin
            count_q <= countNext[CNT_WIDTH-1:0];
          end
        end
        default: state_q <= ST_STABLE;
      endcase
    end
  end

  assign level_o   = level_q;
  // Asserted in the cycle before the level flips so the edge capture lands on the same edge.
  assign changed_o = toggleNow;

endmodule

// File: rtl/power_sense_filter.sv
// Debounced power-sense front end for the POWER_SENSE PIO, with an Avalon-MM
// slave exposing levels, change capture, irq mask and debounce threshold.
module power_sense_filter
  import power_sense_pkg::*;
#(
  parameter int                   WIDTH            = 6,
  parameter int                   SYNC_STAGES      = 2,
  parameter int                   CNT_WIDTH        = 16,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DEBOUNCE = 16'd5000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sense_raw,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] sense_out,
  output logic             irq
);

  logic [WIDTH-1:0]     levelVec;
  logic [WIDTH-1:0]     changedVec;
  logic [WIDTH-1:0]     edgeCap_q;
  logic [WIDTH-1:0]     edgeCap_d;
  logic [WIDTH-1:0]     edgeClear;
  logic [WIDTH-1:0]     mask_q;
  logic [CNT_WIDTH-1:0] thresh_q;
  logic [31:0]          readData_q;
  logic [31:0]          readData_d;
  logic                 irq_q;
  logic                 unusedWriteBits;

  for (genvar i = 0; i < WIDTH; i++) begin : gChannel
    power_sense_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH)
    ) uChannel (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw_i     (sense_raw[i]),
      .thresh_i  (thresh_q),
      .level_o   (levelVec[i]),
      .changed_o (changedVec[i])
    );
  end

  // A new change event outranks a simultaneous write-1-to-clear of the same bit.
  assign edgeClear = (write && address == REG_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign edgeCap_d = (edgeCap_q & ~edgeClear) | changedVec;

  always_comb begin
    readData_d = '0;
    case (address)
      REG_STATE:  readData_d[WIDTH-1:0]     = levelVec;
      REG_EDGE:   readData_d[WIDTH-1:0]     = edgeCap_q;
      REG_MASK:   readData_d[WIDTH-1:0]     = mask_q;
      REG_THRESH: readData_d[CNT_WIDTH-1:0] = thresh_q;
      default:    readData_d                = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgeCap_q  <= '0;
      mask_q     <= '0;
      thresh_q   <= DEFAULT_DEBOUNCE;
      readData_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edgeCap_q  <= edgeCap_d;
      readData_q <= readData_d;
      irq_q      <= |(edgeCap_q & mask_q);
      if (write && address == REG_MASK) begin
        mask_q <= writedata[WIDTH-1:0];
      end
      if (write && address == REG_THRESH) begin
        thresh_q <= writedata[CNT_WIDTH-1:0];
      end
    end
  end

  assign unusedWriteBits = ^writedata;

  assign sense_out = levelVec;
  assign readdata  = readData_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_power_sense_filter.sv
// Scoreboard bench for power_sense_filter: a run-length reference model predicts
// every cycle's outputs, directed phases pin down latency and corner cases.
module tb_power_sense_filter;
  import power_sense_pkg::*;

  localparam int WIDTH = 6;

  logic        clk;
  logic        reset_n;
  logic [5:0]  sense_raw;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [5:0]  sense_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  power_sense_filter #(
    .WIDTH            (6),
    .SYNC_STAGES      (2),
    .CNT_WIDTH        (16),
    .DEFAULT_DEBOUNCE (16'd5000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sense_raw (sense_raw),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .sense_out (sense_out),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  so;
    logic        irqv;
    logic [31:0] rd;
  } exp_t;

  exp_t expQ[$];

  // Reference model: an input change is accepted once the synchronized value has
  // disagreed with the output for T+1 consecutive clock edges.
  logic [5:0]  mSync0, mSync1;
  logic [5:0]  mOut, mEdge, mMask, nOut, nChg, clr;
  logic [15:0] mThresh;
  logic        mIrq;
  logic [31:0] mRead;
  int          mRun[6];
  int          effT;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    if (!reset_n) begin
      mSync0 = '0; mSync1 = '0; mOut = '0; mEdge = '0; mMask = '0;
      mThresh = 16'd5000; mIrq = 1'b0; mRead = '0;
      for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
    end else begin
      effT = (mThresh == 16'd0) ? 1 : int'(mThresh);
      case (address)
        2'd0:    mRead = {26'b0, mOut};
        2'd1:    mRead = {26'b0, mEdge};
        2'd2:    mRead = {26'b0, mMask};
        default: mRead = {16'b0, mThresh};
      endcase
      mIrq = |(mEdge & mMask);
      nOut = mOut;
      nChg = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (mSync1[i] != mOut[i]) begin
          mRun[i]++;
          if (mRun[i] >= effT + 1) begin
            nOut[i] = ~mOut[i];
            nChg[i] = 1'b1;
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      clr   = (write && address == 2'd1) ? writedata[5:0] : 6'd0;
      mEdge = (mEdge & ~clr) | nChg;
      if (write && address == 2'd2) mMask = writedata[5:0];
      if (write && address == 2'd3) mThresh = writedata[15:0];
      mSync1 = mSync0;
      mSync0 = sense_raw;
      mOut   = nOut;
    end
    expQ.push_back('{so: mOut, irqv: mIrq, rd: mRead});
  endtask

  always @(posedge clk) modelStep();

  // Monitor: the DUT presents all three outputs every cycle, compared at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
    end else begin
      e = expQ.pop_front();
      checkOutput("sb_sense_out", {26'b0, sense_out}, {26'b0, e.so});
      checkOutput("sb_irq", {31'b0, irq}, {31'b0, e.irqv});
      checkOutput("sb_readdata", readdata, e.rd);
    end
  end

  task automatic applyStimulus(input logic [5:0] raw, input logic [1:0] addr,
                               input logic wr, input logic [31:0] wd);
    @(negedge clk);
    #1;
    sense_raw = raw;
    address   = addr;
    write     = wr;
    writedata = wd;
  endtask

  task automatic waitLevel(input int bitIdx, input logic lvl, input int limit,
                           output int cycles);
    cycles = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (sense_out[bitIdx] == lvl) begin
        cycles = c;
        break;
      end
    end
  endtask

  logic [31:0] resetVals[4];
  int          cyc;
  logic        rose;
  logic [5:0]  rawRnd;
  logic [31:0] wdRnd;
  logic [1:0]  addrRnd;
  int          pulseLens[3];

  initial begin
    resetVals = '{32'd0, 32'd0, 32'd0, 32'd5000};
    pulseLens = '{3, 4, 5};
    sense_raw = '0; address = '0; write = 1'b0; writedata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      applyStimulus(6'h00, 2'(a), 1'b0, 32'd0);
      @(posedge clk); #1;
      checkOutput("reset_read", readdata, resetVals[a]);
    end
    checkOutput("reset_irq", {31'b0, irq}, 32'd0);

    // Single transition on channel 2 with T=4.
    applyStimulus(6'h00, REG_THRESH, 1'b1, 32'd4);
    applyStimulus(6'h00, REG_MASK, 1'b1, 32'h04);
    applyStimulus(6'h04, REG_EDGE, 1'b0, 32'd0);
    waitLevel(2, 1'b1, 50, cyc);
    checkOutput("rise_latency", 32'(cyc), 32'd7);
    checkOutput("irq_same_cycle", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    checkOutput("irq_next_cycle", {31'b0, irq}, 32'd1);
    applyStimulus(6'h04, REG_EDGE, 1'b0, 32'd0);
    @(posedge clk); #1;
    checkOutput("edge_after_rise", readdata, 32'h04);

    // Glitch rejection on channel 0.
    foreach (pulseLens[p]) begin
      for (int k = 0; k < pulseLens[p]; k++) applyStimulus(6'h05, REG_STATE, 1'b0, 32'd0);
      rose = 1'b0;
      for (int k = 0; k < 20; k++) begin
        applyStimulus(6'h04, REG_STATE, 1'b0, 32'd0);
        @(posedge clk); #1;
        rose |= sense_out[0];
      end
      checkOutput($sformatf("glitch_len%0d", pulseLens[p]), {31'b0, rose},
                  (pulseLens[p] >= 5) ? 32'd1 : 32'd0);
    end

    // Write-1-to-clear in the very cycle channel 0 toggles.
    applyStimulus(6'h04, REG_MASK, 1'b1, 32'h01);
    applyStimulus(6'h04, REG_EDGE, 1'b1, 32'h3F);
    for (int k = 0; k < 6; k++) applyStimulus(6'h05, REG_STATE, 1'b0, 32'd0);
    applyStimulus(6'h05, REG_EDGE, 1'b1, 32'h01);
    applyStimulus(6'h05, REG_EDGE, 1'b0, 32'd0);
    @(posedge clk); #1;
    checkOutput("race_level", {31'b0, sense_out[0]}, 32'd1);
    checkOutput("race_edge", readdata & 32'h1, 32'd1);
    applyStimulus(6'h05, REG_EDGE, 1'b1, 32'h01);
    @(posedge clk); #1;
    checkOutput("clear_irq_hold", {31'b0, irq}, 32'd1);
    applyStimulus(6'h05, REG_EDGE, 1'b0, 32'd0);
    @(posedge clk); #1;
    checkOutput("clear_irq_drop", {31'b0, irq}, 32'd0);
    checkOutput("clear_edge", readdata & 32'h1, 32'd0);

    // Threshold lowered while channel 1 is deep into VERIFY.
    applyStimulus(6'h05, REG_THRESH, 1'b1, 32'd1000);
    applyStimulus(6'h07, REG_STATE, 1'b0, 32'd0);
    for (int k = 0; k < 602; k++) applyStimulus(6'h07, REG_STATE, 1'b0, 32'd0);
    applyStimulus(6'h07, REG_THRESH, 1'b1, 32'd100);
    @(posedge clk); #1;
    checkOutput("lower_thresh_hold", {31'b0, sense_out[1]}, 32'd0);
    applyStimulus(6'h07, REG_STATE, 1'b0, 32'd0);
    @(posedge clk); #1;
    checkOutput("lower_thresh_toggle", {31'b0, sense_out[1]}, 32'd1);

    // Asynchronous reset while channel 3 is verifying.
    applyStimulus(6'h07, REG_THRESH, 1'b1, 32'd4);
    for (int k = 0; k < 4; k++) applyStimulus(6'h0F, REG_STATE, 1'b0, 32'd0);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_sense", {26'b0, sense_out}, 32'd0);
    checkOutput("async_reset_irq", {31'b0, irq}, 32'd0);
    checkOutput("async_reset_read", readdata, 32'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    waitLevel(3, 1'b1, 6000, cyc);
    checkOutput("post_reset_latency", 32'(cyc), 32'd5003);

    // Randomized traffic checked by the scoreboard.
    rawRnd = 6'h0F;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(0, 7) == 0) rawRnd[i] = ~rawRnd[i];
      end
      addrRnd = 2'($urandom_range(0, 3));
      wdRnd   = $urandom;
      if (addrRnd == REG_THRESH) wdRnd = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 6));
      applyStimulus(rawRnd, addrRnd, ($urandom_range(0, 9) == 0), wdRnd);
    end

    repeat (3) applyStimulus(rawRnd, REG_STATE, 1'b0, 32'd0);
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_sense_filter.md
# power_sense_filter

Input conditioner that sits directly upstream of the POWER_SENSE parallel input port. It synchronizes and debounces the raw power-good/sense lines from the board and drives the clean levels onto the PIO's `in_port`. It also provides a small Avalon-MM register slave for the debounce threshold, per-channel change capture and a maskable change interrupt. Firmware reads clean levels through the PIO and change events through this block.

## Interface
Parameters:
- `WIDTH`, 6, number of sense channels (matches the PIO `in_port` width)
- `SYNC_STAGES`, 2, synchronizer flops per channel (must be ≥2)
- `CNT_WIDTH`, 16, debounce counter width
- `DEFAULT_DEBOUNCE`, 16'd5000, reset value of the threshold register (100 µs at 50 MHz)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `sense_raw`  in  WIDTH  asynchronous board sense lines
- `address`  in  2  Avalon-MM word address
- `write`  in  1  Avalon-MM write strobe
- `writedata`  in  32  Avalon-MM write data
- `readdata`  out  32  Avalon-MM read data, registered
- `sense_out`  out  WIDTH  debounced levels, wired to the PIO `in_port`
- `irq`  out  1  level interrupt, registered

## Operation
- Register map:
  - 0: `sense_out` (RO)
  - 1: edge capture, WIDTH bits (write 1 to clear)
  - 2: IRQ mask (RW)
  - 3: threshold, CNT_WIDTH bits (RW)
  - Unused bits read 0. Writes to address 0 are ignored.
- Per-channel FSM has two states, STABLE and VERIFY.
  - STABLE: if the synced input ≠ `sense_out[i]`, go to VERIFY and clear the counter.
  - VERIFY, synced input equals `sense_out[i]`: go back to STABLE. The glitch is rejected and the output is unchanged.
  - VERIFY, counter+1 ≥ effective threshold: toggle `sense_out[i]`, set `edge[i]`, go to STABLE.
  - VERIFY, otherwise: increment the counter.
- Effective threshold is max(threshold, 1), so a threshold of 0 behaves as 1.
- Threshold changes apply immediately, including to channels already in VERIFY. The `≥` compare guarantees termination when the threshold is lowered below the current count.
- Edge capture:
  - A set event and a W1C clear on the same bit in the same cycle: set wins.
  - A clear of bits with no pending event has no effect.
- `irq` is the registered value of |(edge & mask).
- Reads: `readdata` is registered from the current `address` every cycle (no read strobe). Reads have no side effects.

## Timing
- Reset values:
  - `sense_out`, `readdata`, `irq`, edge and mask: 0
  - threshold: DEFAULT_DEBOUNCE
  - all channel FSMs: STABLE with counter 0
- After reset, any channel whose raw input is high is debounced and raises `sense_out` and its edge bit after the normal latency.
- Latency from a raw transition, held steadily, to the `sense_out` update: SYNC_STAGES + T + 1 cycles, where T is the effective threshold.
- Edge bit is set in the same cycle `sense_out` updates. `irq` follows one cycle later.
- Register write takes effect on the next clock edge. `readdata` is valid 1 cycle after `address`.
- A pulse shorter than T cycles after synchronization never reaches `sense_out`.
- Asserting `reset_n` mid-VERIFY aborts the debounce immediately (asynchronous). No edge is recorded.

## Structure
- Shared package `power_sense_pkg`:
  - register address constants `REG_STATE`, `REG_EDGE`, `REG_MASK`, `REG_THRESH`
  - channel state enum {`ST_STABLE`, `ST_VERIFY`}
- Sub-module `power_sense_debounce_ch`: one channel, containing the synchronizer, FSM and counter.
  - Inputs: `clk`, `reset_n`, raw bit, threshold.
  - Outputs: level, one-cycle `changed` pulse.
  - Instantiated WIDTH times from the top, which holds the register file, edge capture and irq.

## Test plan
- **Reset defaults:** reset, then read all four addresses → 0, 0, 0, 5000. `irq` = 0.
- **Single transition:** threshold = 4; raise `sense_raw[2]` and hold → `sense_out[2]` rises exactly 2+4+1 = 7 cycles later; edge = 0x04 in the same cycle; with mask = 0x04, `irq` rises 1 cycle later.
- **Glitch rejection:** threshold = 4; 3-cycle pulse on `sense_raw[0]` → `sense_out` stays 0 and edge stays 0. A 4-cycle pulse produces no rise either; a 5-cycle pulse (T+1 = 5) rises `sense_out[0]`.
- **W1C race:** write 0x01 to address 1 in the same cycle a new `sense_out[0]` toggle occurs → edge[0] remains 1. A later write of 0x01 → edge = 0, `irq` drops 1 cycle after.
- **Threshold lowered mid-VERIFY:** threshold = 1000; after 600 VERIFY cycles write 100 → `sense_out` toggles on the next cycle.
- **Reset mid-VERIFY:** assert `reset_n` low during VERIFY → all outputs are 0 immediately. After release with the input held high → one clean rise after the full latency.
